ntt_seq_ctrl: RTL and testbench

- Parametrised sequencer for the NTT/INTT engine.
- Generates butterfly read addresses (Cooley-Tukey for NTT, Gentleman-Sande for INTT) and twiddle ROM addresses, and issues one coefficient pair per cycle to the dual-port coefficient BRAM.
- Delays each issued address pair through a latency-matched pipe and writes the butterfly results back to the same pair.
- Drains the pipe between layers to prevent read-after-write hazards, and for INTT appends a normalisation pass. Sits between the top-level start/done interface and the BRAM / twiddle ROM / butterfly datapath.

---
 rtl/ntt_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_ntt_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_seq_ctrl.sv
// NTT/INTT sequencer: butterfly and twiddle address generation, latency-matched write-back pipe and INTT normalisation pass.
// Defining NTT_SEQ_CTRL_PERF_EN builds the saturating busy-cycle counter on cycle_count; otherwise it is tied to 0.
module ntt_seq_ctrl #(
  parameter int LOG_N      = 8,
  parameter int NUM_LAYERS = 7,
  parameter int TW_W       = 7,
  parameter int RD_LAT     = 1,
  parameter int BU_LAT     = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_ntt,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             mode_ntt,
  output logic             norm_sel,
  output logic [2:0]       layer,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_a,
  output logic [LOG_N-1:0] rd_addr_b,
  output logic             tw_en,
  output logic [TW_W-1:0]  tw_addr,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_a,
  output logic [LOG_N-1:0] wr_addr_b,
  output logic [15:0]      cycle_count
);

  localparam int LAT = RD_LAT + BU_LAT;
  localparam int PW  = LOG_N - 1;
  localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;

  typedef logic [LOG_N-1:0] addr_t;
  typedef logic [PW-1:0]    pair_t;
  typedef logic [TW_W-1:0]  tw_t;
  typedef logic [CW-1:0]    cnt_t;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_NORM, S_NORM_DRAIN, S_DONE
  } state_t;

  typedef struct packed {
    addr_t a;
    addr_t b;
    tw_t   tw;
  } issue_t;

  state_t state;
  pair_t  p;
  tw_t    g;
  cnt_t   cnt;

  // Half-span exponent llen for a layer: shrinking for Cooley-Tukey, growing for Gentleman-Sande.
  function automatic int shift_of(input logic [2:0] lyr, input logic fwd);
    return fwd ? (LOG_N - 1 - int'(lyr)) : (LOG_N - NUM_LAYERS + int'(lyr));
  endfunction

  function automatic addr_t offset_mask(input int sh);
    return addr_t'((1 << sh) - 1);
  endfunction

  function automatic issue_t bfly_issue(input pair_t pp, input logic [2:0] lyr,
                                        input logic fwd, input tw_t gg);
    issue_t r;
    addr_t  pe;
    addr_t  m;
    int     sh;
    sh   = shift_of(lyr, fwd);
    pe   = addr_t'(pp);
    m    = offset_mask(sh);
    r.a  = ((pe >> sh) << (sh + 1)) | (pe & m);
    r.b  = r.a + addr_t'(1 << sh);
    r.tw = fwd ? (tw_t'(1) + gg) : (tw_t'((1 << NUM_LAYERS) - 1) - gg);
    return r;
  endfunction

  function automatic issue_t norm_issue(input pair_t pp);
    issue_t r;
    r.a  = {pp, 1'b0};
    r.b  = {pp, 1'b1};
    r.tw = '0;
    return r;
  endfunction

  logic grp_end;
  tw_t  g_adv;

  // NOTE: every signal driven here gets a value on every path through the block, so no latch is inferred.
  always_comb begin
    addr_t m;
    m       = offset_mask(shift_of(layer, mode_ntt));
    grp_end = (addr_t'(p) & m) == m;
    g_adv   = g + tw_t'(grp_end);
  end

  logic flush;
  assign flush = abort && (state != S_IDLE);

  // NOTE: state and registered outputs use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mode_ntt <= 1'b0;
      layer    <= '0;
      p        <= '0;
      g        <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      norm_sel <= 1'b0;
      rd_en    <= 1'b0;
      tw_en    <= 1'b0;
      {rd_addr_a, rd_addr_b, tw_addr} <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state    <= S_IDLE;
        busy     <= 1'b0;
        norm_sel <= 1'b0;
        rd_en    <= 1'b0;
        tw_en    <= 1'b0;
        {rd_addr_a, rd_addr_b, tw_addr} <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state    <= S_ISSUE;
              mode_ntt <= is_ntt;
              layer    <= '0;
              p        <= '0;
              g        <= '0;
              busy     <= 1'b1;
              rd_en    <= 1'b1;
              tw_en    <= 1'b1;
              {rd_addr_a, rd_addr_b, tw_addr} <= bfly_issue('0, 3'd0, is_ntt, '0);
            end
          end
          S_ISSUE: begin
            g <= g_adv;
            if (p == '1) begin
              state <= S_DRAIN;
              cnt   <= '0;
              rd_en <= 1'b0;
              tw_en <= 1'b0;
              {rd_addr_a, rd_addr_b, tw_addr} <= '0;
            end else begin
              p <= p + pair_t'(1);
              {rd_addr_a, rd_addr_b, tw_addr} <= bfly_issue(p + pair_t'(1), layer, mode_ntt, g_adv);
            end
          end
          S_DRAIN: begin
            if (cnt == cnt_t'(LAT - 1)) begin
              p <= '0;
              if (layer != 3'(NUM_LAYERS - 1)) begin
                state <= S_ISSUE;
                layer <= layer + 3'd1;
                rd_en <= 1'b1;
                tw_en <= 1'b1;
                {rd_addr_a, rd_addr_b, tw_addr} <= bfly_issue('0, layer + 3'd1, mode_ntt, g);
              end else if (mode_ntt) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state    <= S_NORM;
                norm_sel <= 1'b1;
                rd_en    <= 1'b1;
                {rd_addr_a, rd_addr_b, tw_addr} <= norm_issue('0);
              end
            end else begin
              cnt <= cnt + cnt_t'(1);
            end
          end
          S_NORM: begin
            if (p == '1) begin
              state <= S_NORM_DRAIN;
              cnt   <= '0;
              rd_en <= 1'b0;
              {rd_addr_a, rd_addr_b, tw_addr} <= '0;
            end else begin
              p <= p + pair_t'(1);
              {rd_addr_a, rd_addr_b, tw_addr} <= norm_issue(p + pair_t'(1));
            end
          end
          S_NORM_DRAIN: begin
            if (cnt == cnt_t'(LAT - 1)) begin
              state    <= S_DONE;
              done     <= 1'b1;
              norm_sel <= 1'b0;
            end else begin
              cnt <= cnt + cnt_t'(1);
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Write-back pipe: a pair read in cycle t is written in cycle t+LAT with the same addresses.
  logic [LAT-1:0] vld_pipe;
  addr_t          a_pipe [LAT];
  addr_t          b_pipe [LAT];

  // NOTE: the address stages are reset along with the valid bits so wr_addr_* read 0, not X, out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < LAT; i++) begin
        a_pipe[i] <= '0;
        b_pipe[i] <= '0;
      end
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        vld_pipe[i] <= vld_pipe[i-1] & ~flush;
        a_pipe[i]   <= a_pipe[i-1];
        b_pipe[i]   <= b_pipe[i-1];
      end
      vld_pipe[0] <= rd_en & ~flush;
      a_pipe[0]   <= rd_addr_a;
      b_pipe[0]   <= rd_addr_b;
    end
  end

  assign wr_en     = vld_pipe[LAT-1];
  assign wr_addr_a = a_pipe[LAT-1];
  assign wr_addr_b = b_pipe[LAT-1];

`ifdef NTT_SEQ_CTRL_PERF_EN
  // Counts edges that stay inside the run, so the held value equals cycles from accept to done.
  logic leaving;
  assign leaving = (state == S_DONE) || abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
    end else if (state == S_IDLE) begin
      if (start) cycle_count <= '0;
    end else if (!leaving && cycle_count != 16'hFFFF) begin
      cycle_count <= cycle_count + 16'd1;
    end
  end
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Directed bench for ntt_seq_ctrl: full NTT/INTT address streams, abort, reset and a reduced-size configuration.
// Cycle k counts clock edges after the start-accept edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_ntt_seq_ctrl;

  localparam int LOG_N     = 8;
  localparam int NL        = 7;
  localparam int LAT       = 29;
  localparam int HALF      = 128;
  localparam int LAYER_CYC = HALF + LAT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, is_ntt, abort;
  logic       busy, done, mode_ntt, norm_sel, rd_en, tw_en, wr_en;
  logic [2:0] layer;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [6:0] tw_addr;
  logic [15:0] cycle_count;

  ntt_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_ntt(is_ntt), .abort(abort),
    .busy(busy), .done(done), .mode_ntt(mode_ntt), .norm_sel(norm_sel), .layer(layer),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .tw_en(tw_en), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .cycle_count(cycle_count)
  );

  // Reduced configuration: N=16, three layers, LAT=4.
  logic       s_start;
  logic       s_busy, s_done, s_mode, s_norm, s_rd_en, s_tw_en, s_wr_en;
  logic [2:0] s_layer;
  logic [3:0] s_rd_a, s_rd_b, s_wr_a, s_wr_b;
  logic [2:0] s_tw;
  logic [15:0] s_cc;

  ntt_seq_ctrl #(.LOG_N(4), .NUM_LAYERS(3), .TW_W(3), .RD_LAT(1), .BU_LAT(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .is_ntt(1'b1), .abort(1'b0),
    .busy(s_busy), .done(s_done), .mode_ntt(s_mode), .norm_sel(s_norm), .layer(s_layer),
    .rd_en(s_rd_en), .rd_addr_a(s_rd_a), .rd_addr_b(s_rd_b),
    .tw_en(s_tw_en), .tw_addr(s_tw),
    .wr_en(s_wr_en), .wr_addr_a(s_wr_a), .wr_addr_b(s_wr_b),
    .cycle_count(s_cc)
  );

  int errors = 0;
  int checks = 0;

  int exp_a  [(NL+1)*HALF];
  int exp_b  [(NL+1)*HALF];
  int exp_tw [(NL+1)*HALF];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int perf_expect(input int v);
`ifdef NTT_SEQ_CTRL_PERF_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // Expected issue stream built group by group, independent of the pair-index decomposition.
  task automatic build_model(input bit fwd);
    int idx, gcnt, len;
    idx  = 0;
    gcnt = 0;
    for (int l = 0; l < NL; l++) begin
      len = fwd ? (1 << (LOG_N - 1 - l)) : (1 << (LOG_N - NL + l));
      for (int grp = 0; grp < HALF / len; grp++) begin
        for (int o = 0; o < len; o++) begin
          exp_a[idx]  = grp * 2 * len + o;
          exp_b[idx]  = grp * 2 * len + o + len;
          exp_tw[idx] = fwd ? (1 + gcnt) : ((1 << NL) - 1 - gcnt);
          idx++;
        end
        gcnt++;
      end
    end
    for (int i = 0; i < HALF; i++) begin
      exp_a[idx]  = 2 * i;
      exp_b[idx]  = 2 * i + 1;
      exp_tw[idx] = 0;
      idx++;
    end
  endtask

  task automatic run_full(input bit fwd, input string pfx);
    int n_slots, done_k, rd_bad, wr_bad, ctl_bad, writes;
    int slot, pos, idx, wk, widx;
    bit exp_rd, exp_wr, exp_twen, exp_norm, exp_busy, exp_done;
    n_slots = fwd ? NL : NL + 1;
    done_k  = n_slots * LAYER_CYC;
    rd_bad = 0; wr_bad = 0; ctl_bad = 0; writes = 0;
    build_model(fwd);
    is_ntt = fwd;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    for (int k = 0; k <= done_k + 2; k++) begin
      slot     = k / LAYER_CYC;
      pos      = k % LAYER_CYC;
      idx      = slot * HALF + pos;
      exp_rd   = (slot < n_slots) && (pos < HALF);
      exp_norm = !fwd && (k >= NL * LAYER_CYC) && (k < done_k);
      exp_twen = exp_rd && (slot < NL);
      wk       = k - LAT;
      exp_wr   = (wk >= 0) && (wk / LAYER_CYC < n_slots) && (wk % LAYER_CYC < HALF);
      widx     = (wk >= 0) ? (wk / LAYER_CYC) * HALF + wk % LAYER_CYC : 0;
      exp_busy = (k <= done_k);
      exp_done = (k == done_k);

      if (rd_en !== exp_rd) rd_bad++;
      else if (exp_rd) begin
        if (rd_addr_a !== 8'(exp_a[idx]) || rd_addr_b !== 8'(exp_b[idx])) rd_bad++;
        if (exp_twen && (tw_addr !== 7'(exp_tw[idx]) || layer !== 3'(slot))) rd_bad++;
      end
      if (tw_en !== exp_twen) ctl_bad++;
      if (wr_en !== exp_wr) wr_bad++;
      else if (exp_wr && (wr_addr_a !== 8'(exp_a[widx]) || wr_addr_b !== 8'(exp_b[widx]))) wr_bad++;
      if (busy !== exp_busy || done !== exp_done || norm_sel !== exp_norm) ctl_bad++;
      if (wr_en === 1'b1) writes++;

      if (k == 0) begin
        check({pfx, "_first_rd_en"}, 32'(rd_en), 1);
        check({pfx, "_first_rd_b"}, 32'(rd_addr_b), fwd ? 128 : 2);
        check({pfx, "_first_tw"}, 32'(tw_addr), fwd ? 1 : 127);
        check({pfx, "_mode_ntt"}, 32'(mode_ntt), 32'(fwd));
      end
      if (k == LAT) begin
        check({pfx, "_first_wr_en"}, 32'(wr_en), 1);
        check({pfx, "_first_wr_b"}, 32'(wr_addr_b), fwd ? 128 : 2);
      end
      if (k == LAYER_CYC - 1) check({pfx, "_l0_last_wr_no_rd"}, {30'd0, wr_en, rd_en}, 2);
      if (k == LAYER_CYC) check({pfx, "_l1_first_rd"}, 32'(rd_en), 1);
      if (!fwd && k == (NL - 1) * LAYER_CYC + HALF - 1) check("intt_last_bfly_tw", 32'(tw_addr), 1);
      if (!fwd && k == done_k - 1) check("intt_last_norm_wr", {16'd0, wr_addr_a, wr_addr_b}, {16'd0, 8'd254, 8'd255});
      if (k == done_k) check({pfx, "_done_pulse"}, 32'(done), 1);
      @(negedge clk);
    end
    check({pfx, "_rd_stream_bad_cycles"}, 32'(rd_bad), 0);
    check({pfx, "_wr_stream_bad_cycles"}, 32'(wr_bad), 0);
    check({pfx, "_ctl_bad_cycles"}, 32'(ctl_bad), 0);
    check({pfx, "_write_count"}, 32'(writes), 32'(n_slots * HALF));
    check({pfx, "_cycle_count"}, 32'(cycle_count), 32'(perf_expect(done_k)));
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; start = 1'b0; is_ntt = 1'b0; abort = 1'b0; s_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy_rd_wr_done", {28'd0, busy, rd_en, wr_en, done}, 0);
    check("rst_addrs", {wr_addr_a, rd_addr_a, 9'd0, tw_addr}, 0);
    check("rst_cycle_count", 32'(cycle_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_full(1'b1, "ntt");
    run_full(1'b0, "intt");

    // start while busy is ignored; abort returns to IDLE with the pipe flushed.
    is_ntt = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    is_ntt = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_mode_kept", 32'(mode_ntt), 1);
    check("busy_start_addr_kept", {16'd0, rd_addr_a, rd_addr_b}, {16'd0, 8'd11, 8'd139});
    repeat (388) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", {29'd0, busy, rd_en, wr_en}, 0);
    check("abort_cycle_count", 32'(cycle_count), 32'(perf_expect(399)));
    bad = 0;
    repeat (40) begin
      if (wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    check("abort_no_wr_no_done", 32'(bad), 0);

    // Same-cycle start and abort in IDLE: start wins, abort then cancels.
    is_ntt = 1'b1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_beats_abort", {30'd0, busy, rd_en}, 3);
    @(negedge clk);
    abort = 1'b0;
    check("abort_after_start", {30'd0, busy, rd_en}, 0);
    repeat (LAT + 2) @(negedge clk);

    run_full(1'b1, "ntt_restart");

    // Reset in the middle of an INTT.
    is_ntt = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (499) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ctl", {25'd0, busy, done, mode_ntt, norm_sel, rd_en, tw_en, wr_en}, 0);
    check("midrst_addrs", {rd_addr_b, wr_addr_a, wr_addr_b, 5'd0, layer}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("midrst_quiet_after_release", 32'(bad), 0);

    // Reduced configuration: 12 cycles per layer, done 36 cycles after accept.
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int k = 0; k <= 37; k++) begin
      if (k == 0)  check("s_k0",  {20'd0, s_rd_en, s_rd_a, s_rd_b, s_tw}, {20'd0, 1'b1, 4'd0, 4'd8, 3'd1});
      if (k == 4)  check("s_k4_wr", {23'd0, s_wr_en, s_wr_a, s_wr_b}, {23'd0, 1'b1, 4'd0, 4'd8});
      if (k == 7)  check("s_k7",  {20'd0, s_rd_en, s_rd_a, s_rd_b, s_tw}, {20'd0, 1'b1, 4'd7, 4'd15, 3'd1});
      if (k == 8)  check("s_k8_drain", 32'(s_rd_en), 0);
      if (k == 11) check("s_k11_wr", {22'd0, s_rd_en, s_wr_en, s_wr_a, s_wr_b}, {22'd0, 1'b0, 1'b1, 4'd7, 4'd15});
      if (k == 12) check("s_k12", {20'd0, s_rd_en, s_rd_a, s_rd_b, s_tw}, {20'd0, 1'b1, 4'd0, 4'd4, 3'd2});
      if (k == 16) check("s_k16", {20'd0, s_rd_en, s_rd_a, s_rd_b, s_tw}, {20'd0, 1'b1, 4'd8, 4'd12, 3'd3});
      if (k == 24) check("s_k24", {20'd0, s_rd_en, s_rd_a, s_rd_b, s_tw}, {20'd0, 1'b1, 4'd0, 4'd2, 3'd4});
      if (k == 26) check("s_k26", {20'd0, s_rd_en, s_rd_a, s_rd_b, s_tw}, {20'd0, 1'b1, 4'd4, 4'd6, 3'd5});
      if (k == 31) check("s_k31", {20'd0, s_rd_en, s_rd_a, s_rd_b, s_tw}, {20'd0, 1'b1, 4'd13, 4'd15, 3'd7});
      if (k == 35) check("s_k35_last_wr", {22'd0, s_done, s_wr_en, s_wr_a, s_wr_b}, {22'd0, 1'b0, 1'b1, 4'd13, 4'd15});
      if (k == 36) check("s_k36_done", {30'd0, s_busy, s_done}, 3);
      if (k == 37) check("s_k37_idle", {30'd0, s_busy, s_done}, 0);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
